// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the two-port ROM read arbiter: FSM states,
// request size codes, beat count and alignment checks.
package rom_arb_pkg;

  localparam int BEAT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  function automatic logic [BEAT_W:0] size_to_beats(input logic [1:0] size);
    case (size)
      SZ_HALF: size_to_beats = 3'd2;
      SZ_WORD: size_to_beats = 3'd4;
      default: size_to_beats = 3'd1;
    endcase
  endfunction

  // Reserved size or a half/word not on its natural boundary.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lsb);
    case (size)
      SZ_HALF: is_bad_req = addr_lsb[0];
      SZ_WORD: is_bad_req = (addr_lsb != 2'b00);
      SZ_RSVD: is_bad_req = 1'b1;
      default: is_bad_req = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rom_arb_grant.sv
// Grant selection between fetch (port 0) and data load (port 1).
// ROM_ARB_RR_EN selects round-robin on contention; otherwise port 1 always wins.
module rom_arb_grant (
  input  logic w_clk_low,
  input  logic rst,
  input  logic i_req0_valid,
  input  logic i_req1_valid,
  input  logic i_accept,
  output logic o_grant0,
  output logic o_grant1
);

`ifdef ROM_ARB_RR_EN
  // r_ptr names the port preferred on the next contended cycle.
  logic r_ptr;

  always_ff @(posedge w_clk_low) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= o_grant0;
    end
  end

  assign o_grant0 = i_req0_valid & (~i_req1_valid | ~r_ptr);
  assign o_grant1 = i_req1_valid & (~i_req0_valid |  r_ptr);
`else
  logic w_unused;
  assign w_unused = ^{w_clk_low, rst, i_accept};

  assign o_grant1 = i_req1_valid;
  assign o_grant0 = i_req0_valid & ~i_req1_valid;
`endif

endmodule

// File: rtl/rom_read_arbiter.sv
// Two-port arbiter over a byte-wide combinational ROM: sequences 1/2/4 byte
// reads, assembles little-endian data and returns it with an error flag (see ROM_ARB_RR_EN).
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic              w_clk_low,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_size,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [31:0]       resp0_data,
  output logic              resp0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_size,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [31:0]       resp1_data,
  output logic              resp1_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_illegal
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_port;
  logic [ADDR_W-1:0]   r_base;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   r_last;
  logic [31:0]         r_data;
  logic                r_err;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_idle;
  logic                w_accept;
  logic                w_sel_port;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [1:0]          w_sel_size;
  logic                w_sel_bad;
  logic                w_last_beat;
  logic                w_resp;
  logic [31:0]         w_resp_data;

  rom_arb_grant u_grant (
    .w_clk_low    (w_clk_low),
    .rst          (rst),
    .i_req0_valid (req0_valid),
    .i_req1_valid (req1_valid),
    .i_accept     (w_accept),
    .o_grant0     (w_grant0),
    .o_grant1     (w_grant1)
  );

  assign w_idle     = (r_state == IDLE);
  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;
  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign w_sel_port = w_grant1;
  assign w_sel_addr = w_grant1 ? req1_addr : req0_addr;
  assign w_sel_size = w_grant1 ? req1_size : req0_size;
  assign w_sel_bad  = is_bad_req(w_sel_size, w_sel_addr[1:0]);

  assign w_last_beat = (r_beat == r_last);

  always_comb begin
    // NOTE: next state defaults to the current one so no path through the case infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_sel_bad ? RESP : READ;
      READ: if (w_last_beat) w_state_nxt = RESP;
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk_low) begin
    if (rst) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= IDLE;
      r_port  <= 1'b0;
      r_base  <= '0;
      r_beat  <= '0;
      r_last  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_port <= w_sel_port;
        r_base <= w_sel_addr;
        r_beat <= '0;
        r_last <= BEAT_W'(size_to_beats(w_sel_size) - 3'd1);
        r_data <= '0;
        r_err  <= w_sel_bad;
      end else if (r_state == READ) begin
        r_data[{r_beat, 3'b000} +: 8] <= rom_data;
        r_err  <= r_err | rom_illegal;
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
    end
  end

  // Base plus beat wraps modulo 2^ADDR_W, so reads at the top of memory are legal.
  assign rom_addr = (r_state == READ) ? (r_base + ADDR_W'(r_beat)) : '0;

  assign w_resp      = (r_state == RESP);
  assign w_resp_data = r_err ? ERR_DATA : r_data;

  assign resp0_valid = w_resp & ~r_port;
  assign resp0_data  = resp0_valid ? w_resp_data : 32'h0;
  assign resp0_err   = resp0_valid & r_err;

  assign resp1_valid = w_resp & r_port;
  assign resp1_data  = resp1_valid ? w_resp_data : 32'h0;
  assign resp1_err   = resp1_valid & r_err;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: directed vector table, contention,
// mid-read reset and randomized traffic against a behavioural ROM-read model.
module tb_rom_read_arbiter;

  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef ROM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        w_clk_low;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_addr, req1_addr;
  logic [1:0]  req0_size, req1_size;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_err, resp1_err;
  logic [31:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_illegal;

  logic [7:0]  rom_mem [256];
  logic        rom_lim;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_port;
  logic [31:0] addr_q [$];

  rom_read_arbiter #(.ADDR_W(32), .ERR_DATA(ERRD)) dut (
    .w_clk_low   (w_clk_low),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_size   (req0_size),
    .req0_ready  (req0_ready),
    .resp0_valid (resp0_valid),
    .resp0_data  (resp0_data),
    .resp0_err   (resp0_err),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_size   (req1_size),
    .req1_ready  (req1_ready),
    .resp1_valid (resp1_valid),
    .resp1_data  (resp1_data),
    .resp1_err   (resp1_err),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rom_illegal (rom_illegal)
  );

  // ROM: 256 bytes; with rom_lim set, anything above 0xFF and the hole at 0x81 is illegal.
  assign rom_data    = rom_mem[rom_addr[7:0]];
  assign rom_illegal = rom_lim & ((rom_addr[31:8] != 24'h0) | (rom_addr == 32'h81));

  initial w_clk_low = 1'b0;
  always #5 w_clk_low = ~w_clk_low;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk_low);
    #1;
  endtask

  function automatic logic ref_illegal(input logic [31:0] a);
    return rom_lim && ((a >= 32'h100) || (a == 32'h81));
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[7:0];
    return rom_mem[idx];
  endfunction

  // What a read of (addr,size) must return, and cycles from accept to response.
  function automatic void ref_read(input logic [31:0] a, input logic [1:0] s,
                                   output logic [31:0] d, output logic e, output int lat);
    int nb;
    logic bad;
    nb  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    bad = (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
    if (bad) begin
      d = ERRD; e = 1'b1; lat = 1;
      return;
    end
    d = 32'h0; e = 1'b0;
    for (int i = 0; i < nb; i++) begin
      d = d | (32'(ref_byte(a + 32'(i))) << (8 * i));
      e = e | ref_illegal(a + 32'(i));
    end
    if (e) d = ERRD;
    lat = nb + 1;
  endfunction

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    last_port = 1;
  endtask

  // One request (optionally contended); returns the response actually observed.
  task automatic xact(input logic v0, input logic [31:0] a0, input logic [1:0] s0,
                      input logic v1, input logic [31:0] a1, input logic [1:0] s1,
                      output int exp_port, output int port, output logic [31:0] data,
                      output logic err, output int lat);
    int waitc;
    if (v0 && v1) exp_port = RR_EN ? (1 - last_port) : 1;
    else          exp_port = v1 ? 1 : 0;
    last_port = exp_port;
    req0_valid = v0; req0_addr = a0; req0_size = s0;
    req1_valid = v1; req1_addr = a1; req1_size = s1;
    #1;
    waitc = 0;
    while (!(req0_ready || req1_ready) && waitc < 10) begin
      step();
      waitc++;
    end
    check("accept_bound", 32'(waitc < 10), 32'd1);
    check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
    check("grant_port", 32'(req1_ready), 32'(exp_port));
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    addr_q.delete();
    while (!(resp0_valid || resp1_valid) && lat < 12) begin
      addr_q.push_back(rom_addr);
      step();
      lat++;
    end
    port = resp1_valid ? 1 : 0;
    data = port ? resp1_data : resp0_data;
    err  = port ? resp1_err  : resp0_err;
    check("other_resp_quiet", 32'(port ? resp0_valid : resp1_valid), 32'd0);
    check("rom_addr_in_resp", rom_addr, 32'h0);
    step();
    check("resp_single_pulse", 32'(resp0_valid | resp1_valid), 32'd0);
  endtask

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        lim;
    logic [31:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int          ep, p, lat, got;
    logic [31:0] d, ed;
    logic        e, ee, flag;
    int          elat, exp_p;
    int          got_port [4];
    logic [31:0] got_data [4];

    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
    rom_mem[8'h10] = 8'h11; rom_mem[8'h11] = 8'h22;
    rom_mem[8'h12] = 8'h33; rom_mem[8'h13] = 8'h44;
    rom_lim = 1'b1;
    req0_addr = '0; req0_size = '0; req1_addr = '0; req1_size = '0;

    vecs.push_back('{0, 32'h10,        2'b10, 1'b1, 32'h4433_2211, 1'b0, 5});
    vecs.push_back('{1, 32'h21,        2'b01, 1'b1, ERRD,          1'b1, 1});
    vecs.push_back('{1, 32'h20,        2'b11, 1'b1, ERRD,          1'b1, 1});
    vecs.push_back('{0, 32'h13,        2'b00, 1'b1, 32'h0000_0044, 1'b0, 2});
    vecs.push_back('{1, 32'h12,        2'b01, 1'b1, 32'h0000_4433, 1'b0, 3});
    vecs.push_back('{0, 32'h22,        2'b10, 1'b1, ERRD,          1'b1, 1});
    vecs.push_back('{1, 32'h40,        2'b10, 1'b1, 32'h4342_4140, 1'b0, 5});
    vecs.push_back('{0, 32'hFC,        2'b10, 1'b1, 32'hFFFE_FDFC, 1'b0, 5});
    vecs.push_back('{0, 32'hFE,        2'b10, 1'b1, ERRD,          1'b1, 1});
    vecs.push_back('{0, 32'h80,        2'b10, 1'b1, ERRD,          1'b1, 5});
    vecs.push_back('{1, 32'h100,       2'b01, 1'b1, ERRD,          1'b1, 3});
    vecs.push_back('{1, 32'hFFFF_FFFE, 2'b01, 1'b0, 32'h0000_FFFE, 1'b0, 3});
    vecs.push_back('{1, 32'hFFFF_FFFC, 2'b10, 1'b0, 32'hFFFE_FDFC, 1'b0, 5});
    vecs.push_back('{0, 32'h7F,        2'b00, 1'b1, 32'h0000_007F, 1'b0, 2});
    vecs.push_back('{1, 32'h81,        2'b00, 1'b1, ERRD,          1'b1, 2});

    // Reset state
    do_reset();
    rst = 1'b1;
    step();
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_resp_valid", 32'({resp0_valid, resp1_valid}), 32'd0);
    check("rst_resp_err", 32'({resp0_err, resp1_err}), 32'd0);
    check("rst_resp0_data", resp0_data, 32'h0);
    check("rst_resp1_data", resp1_data, 32'h0);
    check("rst_rom_addr", rom_addr, 32'h0);
    rst = 1'b0;
    step();

    // Directed vectors
    foreach (vecs[i]) begin
      rom_lim = vecs[i].lim;
      xact(vecs[i].port == 0, vecs[i].addr, vecs[i].size,
           vecs[i].port == 1, vecs[i].addr, vecs[i].size, ep, p, d, e, lat);
      check($sformatf("vec%0d_port", i), 32'(p), 32'(vecs[i].port));
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_beats", i), 32'(addr_q.size()), 32'(vecs[i].lat - 1));
      foreach (addr_q[j])
        check($sformatf("vec%0d_rom_addr%0d", i, j), addr_q[j], vecs[i].addr + 32'(j));
    end
    rom_lim = 1'b1;

    // Continuous contention, word reads on both ports
    do_reset();
    req0_addr = 32'h10; req0_size = 2'b10;
    req1_addr = 32'h40; req1_size = 2'b10;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    got = 0; flag = 1'b0;
    for (int c = 0; c < 80 && got < 4; c++) begin
      if (req0_ready && req1_ready) flag = 1'b1;
      if (resp0_valid || resp1_valid) begin
        got_port[got] = resp1_valid ? 1 : 0;
        got_data[got] = resp1_valid ? resp1_data : resp0_data;
        got++;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_both_ready", 32'(flag), 32'd0);
    check("cont_resp_count", 32'(got), 32'd4);
    for (int i = 0; i < got; i++) begin
      exp_p = RR_EN ? (1 - last_port) : 1;
      last_port = exp_p;
      check($sformatf("cont%0d_port", i), 32'(got_port[i]), 32'(exp_p));
      check($sformatf("cont%0d_data", i), got_data[i], exp_p ? 32'h4342_4140 : 32'h4433_2211);
    end
    step(); step();

    // Reset in the middle of a word read
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h40; req0_size = 2'b10;
    #1;
    check("mid_rst_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    step(); step();
    check("mid_rst_beat2_addr", rom_addr, 32'h42);
    rst = 1'b1;
    step();
    check("mid_rst_rom_addr", rom_addr, 32'h0);
    check("mid_rst_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
    rst = 1'b0;
    last_port = 1;
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (resp0_valid || resp1_valid || rom_addr != 32'h0) flag = 1'b1;
      step();
    end
    check("mid_rst_quiet", 32'(flag), 32'd0);
    xact(1'b1, 32'h40, 2'b10, 1'b0, 32'h0, 2'b00, ep, p, d, e, lat);
    check("mid_rst_rereq_data", d, 32'h4342_4140);
    check("mid_rst_rereq_lat", 32'(lat), 32'd5);

    // Randomized traffic against the reference model
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a0, a1;
      logic [1:0]  s0, s1;
      int          mode;
      a0 = (k % 3 == 0) ? 32'($urandom_range(32'h7C, 32'h87)) :
           (k % 3 == 1) ? 32'($urandom_range(32'hF8, 32'h107)) : 32'($urandom_range(0, 32'h1FF));
      a1 = 32'($urandom_range(0, 32'h1FF));
      s0 = 2'($urandom_range(0, 3));
      s1 = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 2);
      xact(mode != 1, a0, s0, mode != 0, a1, s1, ep, p, d, e, lat);
      if (ep == 1) ref_read(a1, s1, ed, ee, elat);
      else         ref_read(a0, s0, ed, ee, elat);
      check($sformatf("rnd%0d_port", k), 32'(p), 32'(ep));
      check($sformatf("rnd%0d_data", k), d, ed);
      check($sformatf("rnd%0d_err", k), 32'(e), 32'(ee));
      check($sformatf("rnd%0d_lat", k), 32'(lat), 32'(elat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
